// File: rtl/collide_pkg.sv
// Shared definitions for the sphere-sphere collider and its dispatcher:
// field widths, operand/contact packing offsets, FSM state encoding and float constants.
package collide_pkg;

    localparam int FLT_W     = 32;
    localparam int PAIR_W    = 256;
    localparam int CONTACT_W = 224;

    // Operand pair packing {x1,y1,z1,r1,x2,y2,z2,r2}, x1 in the MSBs
    localparam int X1_OFF = 224;
    localparam int Y1_OFF = 192;
    localparam int Z1_OFF = 160;
    localparam int R1_OFF = 128;
    localparam int X2_OFF = 96;
    localparam int Y2_OFF = 64;
    localparam int Z2_OFF = 32;
    localparam int R2_OFF = 0;

    // Contact packing {cx,cy,cz,nx,ny,nz,depth}, cx in the MSBs
    localparam int CX_OFF    = 192;
    localparam int CY_OFF    = 160;
    localparam int CZ_OFF    = 128;
    localparam int NX_OFF    = 96;
    localparam int NY_OFF    = 64;
    localparam int NZ_OFF    = 32;
    localparam int DEPTH_OFF = 0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        RST_HOLD  = 3'd2,
        WAIT_DONE = 3'd3,
        RESULT    = 3'd4
    } dispatch_state_e;

    localparam logic [FLT_W-1:0] ONE_F  = 32'h3F80_0000;
    localparam logic [FLT_W-1:0] ZERO_F = 32'h0000_0000;

    function automatic logic [FLT_W-1:0] contact_field(input logic [CONTACT_W-1:0] c,
                                                       input int off);
        return c[off +: FLT_W];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding pending sphere-pair jobs; head word is visible on rdata
// (show-ahead), so a pop and the read of that entry happen on the same edge.
module sync_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic             CLK_d,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // A push into a full FIFO is only taken when the head leaves on the same edge
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge CLK_d or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK_d) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/sphere_pair_dispatcher.sv
// Queues sphere-pair jobs, sequences the collider (load, reset pulse, wait done) and returns
// one result per job in order. Build option DISPATCH_TIMEOUT_EN adds a WAIT_DONE watchdog.
module sphere_pair_dispatcher
    import collide_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 4096,
    parameter int CNT_W      = 16
) (
    input  logic                 CLK_d,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAIR_W-1:0]    in_pair,
    output logic [PAIR_W-1:0]    col_pair,
    output logic                 col_rst,
    input  logic                 col_done,
    input  logic                 col_ret,
    input  logic [CONTACT_W-1:0] col_contact,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_hit,
    output logic [CONTACT_W-1:0] res_contact,
    output logic                 res_timeout,
    output logic                 busy,
    output logic [CNT_W-1:0]     done_count,
    output logic [2:0]           state_dbg
);

    localparam logic [2:0] S_IDLE      = 3'(IDLE);
    localparam logic [2:0] S_LOAD      = 3'(LOAD);
    localparam logic [2:0] S_RST_HOLD  = 3'(RST_HOLD);
    localparam logic [2:0] S_WAIT_DONE = 3'(WAIT_DONE);
    localparam logic [2:0] S_RESULT    = 3'(RESULT);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("sphere_pair_dispatcher: DEPTH must be a power of two >= 2");
    end
    if (RST_CYCLES < 1 || TIMEOUT < 1) begin : g_cycles_chk
        $error("sphere_pair_dispatcher: RST_CYCLES and TIMEOUT must be >= 1");
    end

    logic [2:0]        state;
    logic [RW-1:0]     rst_cnt;
    logic              init_q;
    logic              done_m;
    logic              done_s;
    logic              seen_low;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              done_hit;
    logic              to_hit;
    logic [PAIR_W-1:0] head;

    // Both streams: a transfer happens on a rising CLK_d edge where valid and ready are both 1;
    // a producer holds valid and its payload stable until that edge.
    assign in_ready = init_q & ~fifo_full;
    assign push     = in_valid & in_ready;
    assign pop      = (state == S_IDLE) & ~fifo_empty & ~res_valid;
    assign busy     = (state != S_IDLE) | ~fifo_empty;
    assign state_dbg = state;

    // A done that was already high on entry belongs to the previous job; require a low first
    assign done_hit = (state == S_WAIT_DONE) & seen_low & done_s;

    sync_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (DEPTH)
    ) u_job_fifo (
        .CLK_d (CLK_d),
        .rst   (rst),
        .push  (push),
        .wdata (in_pair),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge CLK_d or negedge rst) begin
        if (!rst) begin
            init_q <= 1'b0;
            done_m <= 1'b0;
            done_s <= 1'b0;
        end else begin
            init_q <= 1'b1;
            done_m <= col_done;
            done_s <= done_m;
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] to_cnt;

    assign to_hit = (state == S_WAIT_DONE) & ~done_hit & (to_cnt == TO_LAST);

    always_ff @(posedge CLK_d or negedge rst) begin
        if (!rst) begin
            to_cnt      <= '0;
            res_timeout <= 1'b0;
        end else begin
            if (state == S_LOAD)                to_cnt <= '0;
            else if (state == S_WAIT_DONE)      to_cnt <= to_cnt + 1'b1;
            if (to_hit)                         res_timeout <= 1'b1;
            else if (res_valid && res_ready)    res_timeout <= 1'b0;
        end
    end
`else
    assign to_hit      = 1'b0;
    assign res_timeout = 1'b0;
`endif

    always_ff @(posedge CLK_d or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            col_pair    <= '0;
            col_rst     <= 1'b0;
            rst_cnt     <= '0;
            seen_low    <= 1'b0;
            res_valid   <= 1'b0;
            res_hit     <= 1'b0;
            res_contact <= '0;
            done_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    col_rst <= 1'b0;
                    if (pop) begin
                        col_pair <= head;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    rst_cnt  <= '0;
                    seen_low <= 1'b0;
                    state    <= S_RST_HOLD;
                end
                S_RST_HOLD: begin
                    if (rst_cnt == RST_LAST) begin
                        col_rst <= 1'b1;
                        state   <= S_WAIT_DONE;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!done_s) seen_low <= 1'b1;
                    if (done_hit) begin
                        res_hit     <= col_ret;
                        res_contact <= col_contact;
                        res_valid   <= 1'b1;
                        state       <= S_RESULT;
                    end else if (to_hit) begin
                        res_hit     <= 1'b0;
                        res_contact <= '0;
                        res_valid   <= 1'b1;
                        state       <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    // Handing off the result also re-arms the collider for the next job
                    if (res_ready) begin
                        res_valid  <= 1'b0;
                        done_count <= done_count + 1'b1;
                        col_rst    <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sphere_pair_dispatcher.sv
// Directed bench for sphere_pair_dispatcher with a behavioural collider model;
// the watchdog scenario runs only when DISPATCH_TIMEOUT_EN is defined.
module tb_sphere_pair_dispatcher;
    import collide_pkg::*;

    logic         CLK_d = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_pair;
    logic [255:0] col_pair;
    logic         col_rst;
    logic         col_done = 1'b0;
    logic         col_ret;
    logic [223:0] col_contact;
    logic         res_valid;
    logic         res_ready;
    logic         res_hit;
    logic [223:0] res_contact;
    logic         res_timeout;
    logic         busy;
    logic [15:0]  done_count;
    logic [2:0]   state_dbg;

    // collider model controls
    logic         model_en;
    logic         model_echo;
    logic         model_ret;
    logic [223:0] model_contact;
    int           model_lat;
    int           m_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [255:0] exp_q[$];

    always #5 CLK_d = ~CLK_d;

    sphere_pair_dispatcher #(
        .DEPTH      (4),
        .RST_CYCLES (2),
        .TIMEOUT    (100),
        .CNT_W      (16)
    ) dut (
        .CLK_d       (CLK_d),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pair     (in_pair),
        .col_pair    (col_pair),
        .col_rst     (col_rst),
        .col_done    (col_done),
        .col_ret     (col_ret),
        .col_contact (col_contact),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_hit     (res_hit),
        .res_contact (res_contact),
        .res_timeout (res_timeout),
        .busy        (busy),
        .done_count  (done_count),
        .state_dbg   (state_dbg)
    );

    // Collider: raises done model_lat cycles after leaving reset, clears it while in reset
    always @(posedge CLK_d) begin
        if (col_rst == 1'b0) begin
            m_cnt    <= 0;
            col_done <= 1'b0;
        end else if (model_en && !col_done) begin
            if (m_cnt == model_lat - 1) col_done <= 1'b1;
            else                        m_cnt <= m_cnt + 1;
        end
    end

    always_comb begin
        col_ret     = model_echo ? col_pair[0]      : model_ret;
        col_contact = model_echo ? col_pair[255:32] : model_contact;
    end

    task automatic push_job(input logic [255:0] p, output bit ok);
        int n = 0;
        in_pair  = p;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge CLK_d);
            n++;
        end
        ok = in_ready;
        @(negedge CLK_d);
        in_valid = 1'b0;
    endtask

    task automatic pop_result(input logic exp_hit, input logic [223:0] exp_c,
                              input logic exp_to, input string nm);
        int n = 0;
        res_ready = 1'b1;
        while (!res_valid && n < 500) begin
            @(negedge CLK_d);
            n++;
        end
        n_cmp++;
        if (res_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_valid: res_valid=%b after %0d cycles, expected 1", nm, res_valid, n);
        end else begin
            n_cmp++;
            if (res_hit !== exp_hit) begin
                n_bad++;
                $display("FAIL %s_hit: got %b expected %b", nm, res_hit, exp_hit);
            end
            n_cmp++;
            if (res_contact !== exp_c) begin
                n_bad++;
                $display("FAIL %s_contact: got %h expected %h", nm, res_contact, exp_c);
            end
            n_cmp++;
            if (res_timeout !== exp_to) begin
                n_bad++;
                $display("FAIL %s_timeout: got %b expected %b", nm, res_timeout, exp_to);
            end
        end
        @(negedge CLK_d);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK_d);
        n_cmp++;
        if ({col_rst, res_valid, res_hit, res_timeout, busy, in_ready} !== 6'b0) begin
            n_bad++;
            $display("FAIL rst_flags: {col_rst,res_valid,res_hit,res_timeout,busy,in_ready}=%b expected 000000",
                     {col_rst, res_valid, res_hit, res_timeout, busy, in_ready});
        end
        n_cmp++;
        if (col_pair !== 256'h0 || res_contact !== 224'h0 || done_count !== 16'd0) begin
            n_bad++;
            $display("FAIL rst_data: col_pair=%h res_contact=%h done_count=%0d expected zeros",
                     col_pair, res_contact, done_count);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_release_ready: in_ready=%b expected 0 before first clock", in_ready);
        end
        @(negedge CLK_d);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_first_clock_ready: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_no_hit();
        logic [255:0] p;
        bit ok;
        int hold = 0;
        int n = 0;
        int lat = 0;
        p = {ZERO_F, ZERO_F, ZERO_F, ONE_F, 32'h40A0_0000, ZERO_F, ZERO_F, ONE_F};
        model_en = 1'b1; model_echo = 1'b0; model_lat = 20; model_ret = 1'b0; model_contact = '0;
        push_job(p, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL nohit_accept: in_ready=%b expected 1", in_ready); end
        while (state_dbg != WAIT_DONE && n < 50) begin
            if (state_dbg == RST_HOLD && col_rst == 1'b0) hold++;
            @(negedge CLK_d);
            n++;
        end
        n_cmp++;
        if (hold != 2) begin n_bad++; $display("FAIL nohit_rst_low: col_rst low %0d cycles expected 2", hold); end
        n_cmp++;
        if (col_rst !== 1'b1 || col_pair !== p) begin
            n_bad++;
            $display("FAIL nohit_operands: col_rst=%b col_pair=%h expected 1 and %h", col_rst, col_pair, p);
        end
        while (!res_valid && lat < 100) begin
            @(negedge CLK_d);
            lat++;
        end
        // 20 collider cycles + 2 synchroniser + 1 capture
        n_cmp++;
        if (lat != 23) begin n_bad++; $display("FAIL nohit_latency: %0d cycles expected 23", lat); end
        pop_result(1'b0, 224'h0, 1'b0, "nohit");
        n_cmp++;
        if (done_count !== 16'd1) begin n_bad++; $display("FAIL nohit_count: done_count=%0d expected 1", done_count); end
    endtask

    task automatic test_hit();
        logic [255:0] p;
        logic [223:0] c;
        bit ok;
        int n = 0;
        p = {ZERO_F, ZERO_F, ZERO_F, ONE_F, 32'h3FC0_0000, ZERO_F, ZERO_F, ONE_F};
        c = {32'h3F40_0000, ZERO_F, ZERO_F, 32'h3F80_0000, ZERO_F, ZERO_F, 32'h3F00_0000};
        model_en = 1'b1; model_echo = 1'b0; model_lat = 8; model_ret = 1'b1; model_contact = c;
        push_job(p, ok);
        while (!res_valid && n < 200) begin
            @(negedge CLK_d);
            n++;
        end
        n_cmp++;
        if (res_contact[31:0] !== 32'h3F00_0000) begin
            n_bad++;
            $display("FAIL hit_depth: got %h expected 3f000000", res_contact[31:0]);
        end
        n_cmp++;
        if (res_contact[127:96] !== 32'h3F80_0000) begin
            n_bad++;
            $display("FAIL hit_nx: got %h expected 3f800000", res_contact[127:96]);
        end
        pop_result(1'b1, c, 1'b0, "hit");
        n_cmp++;
        if (done_count !== 16'd2) begin n_bad++; $display("FAIL hit_count: done_count=%0d expected 2", done_count); end
    endtask

    task automatic test_fifo_full();
        logic [255:0] p;
        logic [31:0] pv;
        bit ok;
        int acc = 0;
        model_en = 1'b0; model_echo = 1'b1; model_lat = 3;
        for (int i = 0; i < 6; i++) begin
            pv = 32'h4100_0000 + 32'(i);
            p  = {pv, pv, pv, pv, pv, pv, pv, pv};
            push_job(p, ok);
            if (ok) begin
                acc++;
                exp_q.push_back(p);
            end
        end
        n_cmp++;
        if (acc != 5) begin n_bad++; $display("FAIL full_accepted: %0d jobs accepted expected 5", acc); end
        n_cmp++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL full_ready: in_ready=%b busy=%b expected 0 and 1", in_ready, busy);
        end
        model_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            p = exp_q.pop_front();
            pop_result(p[0], p[255:32], 1'b0, $sformatf("drain%0d", k));
        end
        n_cmp++;
        if (done_count !== 16'd7 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL full_drained: done_count=%0d busy=%b expected 7 and 0", done_count, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] pa;
        logic [255:0] pb;
        bit ok;
        int n = 0;
        int bad = 0;
        pa = {8{32'h4200_0001}};
        pb = {8{32'h4300_0002}};
        model_en = 1'b1; model_echo = 1'b1; model_lat = 5;
        push_job(pa, ok);
        push_job(pb, ok);
        while (!res_valid && n < 200) begin
            @(negedge CLK_d);
            n++;
        end
        for (int k = 0; k < 50; k++) begin
            if (res_valid !== 1'b1 || res_hit !== pa[0] || res_contact !== pa[255:32] ||
                state_dbg == LOAD || col_rst !== 1'b1 || done_count !== 16'd7 || col_pair !== pa)
                bad++;
            @(negedge CLK_d);
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL bp_stable: %0d unstable cycles expected 0", bad); end
        res_ready = 1'b1;
        @(negedge CLK_d);
        res_ready = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b0 || done_count !== 16'd8 || col_rst !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_handoff: res_valid=%b done_count=%0d col_rst=%b expected 0, 8, 0",
                     res_valid, done_count, col_rst);
        end
        @(negedge CLK_d);
        n_cmp++;
        if (state_dbg !== 3'd1 || col_pair !== pb) begin
            n_bad++;
            $display("FAIL bp_next_load: state=%0d col_pair=%h expected 1 and %h", state_dbg, col_pair, pb);
        end
        pop_result(pb[0], pb[255:32], 1'b0, "bp_b");
        n_cmp++;
        if (done_count !== 16'd9) begin n_bad++; $display("FAIL bp_count: done_count=%0d expected 9", done_count); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0;
        int seen = 0;
        model_en = 1'b0; model_echo = 1'b1; model_lat = 4;
        for (int i = 0; i < 3; i++) push_job({8{32'h4400_0010 + 32'(i)}}, ok);
        while (state_dbg != WAIT_DONE && n < 50) begin
            @(negedge CLK_d);
            n++;
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({col_rst, res_valid, res_hit, res_timeout, busy, in_ready} !== 6'b0 || state_dbg !== 3'd0) begin
            n_bad++;
            $display("FAIL mid_rst_flags: flags=%b state=%0d expected 000000 and 0",
                     {col_rst, res_valid, res_hit, res_timeout, busy, in_ready}, state_dbg);
        end
        n_cmp++;
        if (col_pair !== 256'h0 || res_contact !== 224'h0 || done_count !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_rst_data: col_pair=%h res_contact=%h done_count=%0d expected zeros",
                     col_pair, res_contact, done_count);
        end
        @(negedge CLK_d);
        rst = 1'b1;
        model_en = 1'b1;
        res_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK_d);
            if (res_valid || busy || done_count != 16'd0) seen++;
        end
        res_ready = 1'b0;
        n_cmp++;
        if (seen != 0) begin n_bad++; $display("FAIL mid_no_result: %0d active cycles after release expected 0", seen); end
    endtask

`ifdef DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int n = 0;
        int lat = 0;
        model_en = 1'b0; model_echo = 1'b0; model_ret = 1'b1; model_contact = {7{32'h3F80_0000}};
        push_job({8{32'h4500_0000}}, ok);
        while (state_dbg != WAIT_DONE && n < 50) begin
            @(negedge CLK_d);
            n++;
        end
        while (!res_valid && lat < 300) begin
            @(negedge CLK_d);
            lat++;
        end
        n_cmp++;
        if (lat != 100) begin n_bad++; $display("FAIL timeout_latency: %0d cycles expected 100", lat); end
        pop_result(1'b0, 224'h0, 1'b1, "timeout");
    endtask
`endif

    initial begin
        in_valid = 1'b0; in_pair = '0; res_ready = 1'b0;
        model_en = 1'b0; model_echo = 1'b0; model_ret = 1'b0; model_contact = '0; model_lat = 1;
        test_reset();
        test_no_hit();
        test_hit();
        test_fifo_full();
        test_backpressure();
        test_reset_mid();
`ifdef DISPATCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 20000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
